// File: rtl/student_fir_seq_pkg.sv
// Shared types and constants for the FIR sample sequencer.
package student_fir_seq_pkg;

    localparam int unsigned SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } fir_seq_state_e;

endpackage : student_fir_seq_pkg

// File: rtl/student_fir_seq_sat.sv
// Arithmetic right shift of the wide FIR result, clamped to codec range.
module student_fir_seq_sat
    import student_fir_seq_pkg::*;
#(
    parameter int unsigned DATA_SIZE         = 16,
    parameter int unsigned DATA_SIZE_FIR_OUT = 64
) (
    input  logic signed [DATA_SIZE_FIR_OUT-1:0] y_i,
    input  logic        [SHIFT_W-1:0]           shift_i,
    output logic        [DATA_SIZE-1:0]         sat_o
);

    localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SAT_MAX =
        {{(DATA_SIZE_FIR_OUT-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE_FIR_OUT-1:0] SAT_MIN =
        {{(DATA_SIZE_FIR_OUT-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [DATA_SIZE_FIR_OUT-1:0] shifted;

    always_comb begin
        shifted = y_i >>> shift_i;
        if (shifted > SAT_MAX) begin
            sat_o = SAT_MAX[DATA_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_o = SAT_MIN[DATA_SIZE-1:0];
        end else begin
            sat_o = shifted[DATA_SIZE-1:0];
        end
    end

endmodule : student_fir_seq_sat

// File: rtl/student_fir_sequencer.sv
// Per-frame sequencer between the I2S handler and the FIR: issue, wait, saturate, return.
module student_fir_sequencer
    import student_fir_seq_pkg::*;
#(
    parameter int unsigned DATA_SIZE         = 16,
    parameter int unsigned DATA_SIZE_FIR_OUT = 64,
    parameter int unsigned TIMEOUT_CYCLES    = 2048,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         bypass_i,
    input  logic [SHIFT_W-1:0]           shift_i,
    input  logic                         clear_cnt_i,
    input  logic                         iis_valid_i,
    input  logic [DATA_SIZE-1:0]         iis_sample_i,
    output logic                         fir_valid_o,
    output logic [DATA_SIZE-1:0]         fir_sample_o,
    input  logic                         fir_done_i,
    input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
    output logic                         out_valid_o,
    output logic [DATA_SIZE-1:0]         out_sample_o,
    output logic                         busy_o,
    output logic [CNT_WIDTH-1:0]         overrun_cnt_o,
    output logic [CNT_WIDTH-1:0]         timeout_cnt_o
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    fir_seq_state_e         state_q, state_d;
    logic [DATA_SIZE-1:0]   sample_q, sample_d;
    logic                   bypass_q, bypass_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic                   fir_valid_q, fir_valid_d;
    logic [DATA_SIZE-1:0]   fir_sample_q, fir_sample_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_SIZE-1:0]   out_sample_q, out_sample_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]   timeout_q, timeout_d;
    logic                   timeout_hit;
    logic [DATA_SIZE-1:0]   sat_y;

    student_fir_seq_sat #(
        .DATA_SIZE        (DATA_SIZE),
        .DATA_SIZE_FIR_OUT(DATA_SIZE_FIR_OUT)
    ) u_sat (
        .y_i    (fir_y_i),
        .shift_i(shift_i),
        .sat_o  (sat_y)
    );

    // Strobes are registered from the decision that produces them: the FIR
    // result strobes on entry to OUTPUT, the bypass result strobes on leaving it.
    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        bypass_d     = bypass_q;
        timer_d      = timer_q;
        fir_valid_d  = 1'b0;
        fir_sample_d = fir_sample_q;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        timeout_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (iis_valid_i && enable_i) begin
                    sample_d = iis_sample_i;
                    bypass_d = bypass_i;
                    if (bypass_i) begin
                        state_d = OUTPUT;
                    end else begin
                        state_d      = ISSUE;
                        fir_valid_d  = 1'b1;
                        fir_sample_d = iis_sample_i;
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fir_done_i) begin
                    out_valid_d  = 1'b1;
                    out_sample_d = sat_y;
                    state_d      = OUTPUT;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            OUTPUT: begin
                if (bypass_q) begin
                    out_valid_d  = 1'b1;
                    out_sample_d = sample_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (clear_cnt_i) begin
            overrun_d = '0;
            timeout_d = '0;
        end else begin
            if (iis_valid_i && (state_q != IDLE) && (overrun_q != '1)) begin
                overrun_d = overrun_q + CNT_WIDTH'(1);
            end
            if (timeout_hit && (timeout_q != '1)) begin
                timeout_d = timeout_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            bypass_q     <= 1'b0;
            timer_q      <= '0;
            fir_valid_q  <= 1'b0;
            fir_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            busy_q       <= 1'b0;
            overrun_q    <= '0;
            timeout_q    <= '0;
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            bypass_q     <= bypass_d;
            timer_q      <= timer_d;
            fir_valid_q  <= fir_valid_d;
            fir_sample_q <= fir_sample_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign fir_valid_o   = fir_valid_q;
    assign fir_sample_o  = fir_sample_q;
    assign out_valid_o   = out_valid_q;
    assign out_sample_o  = out_sample_q;
    assign busy_o        = busy_q;
    assign overrun_cnt_o = overrun_q;
    assign timeout_cnt_o = timeout_q;

endmodule : student_fir_sequencer

// File: tb/tb_student_fir_sequencer.sv
// Directed plus randomized bench for student_fir_sequencer against a cycle-level reference model.
module tb_student_fir_sequencer;

    localparam int DS = 16;
    localparam int DW = 64;
    localparam int T  = 64;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          bypass;
    logic [5:0]    shift;
    logic          clear_cnt;
    logic          iis_valid;
    logic [DS-1:0] iis_sample;
    logic          fir_valid;
    logic [DS-1:0] fir_sample;
    logic          fir_done;
    logic [DW-1:0] fir_y;
    logic          out_valid;
    logic [DS-1:0] out_sample;
    logic          busy;
    logic [CW-1:0] overrun_cnt;
    logic [CW-1:0] timeout_cnt;

    student_fir_sequencer #(
        .DATA_SIZE        (DS),
        .DATA_SIZE_FIR_OUT(DW),
        .TIMEOUT_CYCLES   (T),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .bypass_i     (bypass),
        .shift_i      (shift),
        .clear_cnt_i  (clear_cnt),
        .iis_valid_i  (iis_valid),
        .iis_sample_i (iis_sample),
        .fir_valid_o  (fir_valid),
        .fir_sample_o (fir_sample),
        .fir_done_i   (fir_done),
        .fir_y_i      (fir_y),
        .out_valid_o  (out_valid),
        .out_sample_o (out_sample),
        .busy_o       (busy),
        .overrun_cnt_o(overrun_cnt),
        .timeout_cnt_o(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [DS-1:0] prev_out;
    int exp_ovr;
    int exp_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DS-1:0] ref_sat(input logic [63:0] y, input int sh);
        longint v;
        v = $signed(y);
        v = v >>> sh;
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_ovr"}, overrun_cnt, exp_ovr);
        chk({tag, "_to"}, timeout_cnt, exp_to);
    endtask

    // d = cycles from fir_valid to fir_done (0 -> done during ISSUE, > T -> late)
    task automatic run_fir(input logic [DS-1:0] s, input logic [63:0] y, input int sh,
                           input int d, input int ovr_k, input bit ovr_clr);
        int lat;
        bit done_ok;
        logic [DS-1:0] exp;
        done_ok = (d >= 1) && (d <= T);
        lat = done_ok ? d + 1 : T + 1;
        exp = done_ok ? ref_sat(y, sh) : prev_out;
        iis_valid  = 1'b1;
        iis_sample = s;
        bypass     = 1'b0;
        shift      = 6'(sh);
        fir_y      = y;
        step();
        iis_valid  = 1'b0;
        iis_sample = DS'($urandom);
        bypass     = 1'($urandom);
        fir_done   = (d == 0);
        chk("issue_fir_valid", fir_valid, 1);
        chk("issue_fir_sample", fir_sample, s);
        chk("issue_busy", busy, 1);
        chk("issue_out_valid", out_valid, 0);
        for (int k = 1; k <= lat + 1; k++) begin
            step();
            if (ovr_k >= 1 && k == ovr_k + 1) begin
                if (ovr_clr) begin
                    exp_ovr = 0;
                    exp_to  = 0;
                end else begin
                    exp_ovr++;
                end
            end
            if (!done_ok && k == lat && !(ovr_clr && k == ovr_k + 1)) exp_to++;
            fir_done  = (k == d);
            iis_valid = (k == ovr_k);
            clear_cnt = (k == ovr_k) && ovr_clr;
            chk("wait_out_valid", out_valid, (k == lat));
            chk("wait_fir_valid", fir_valid, 0);
            chk("wait_busy", busy, (k <= lat));
            if (k == lat) begin
                chk("out_sample", out_sample, exp);
                chk("fir_sample_held", fir_sample, s);
            end
            chk_counters("wait_cnt");
        end
        fir_done  = 1'b0;
        iis_valid = 1'b0;
        clear_cnt = 1'b0;
        step();
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_out_hold", out_sample, exp);
        chk_counters("post_cnt");
        prev_out = exp;
    endtask

    task automatic run_byp(input logic [DS-1:0] s);
        iis_valid  = 1'b1;
        iis_sample = s;
        bypass     = 1'b1;
        step();
        iis_valid = 1'b0;
        bypass    = 1'($urandom);
        chk("byp_c1_out_valid", out_valid, 0);
        chk("byp_c1_fir_valid", fir_valid, 0);
        chk("byp_c1_busy", busy, 1);
        step();
        chk("byp_c2_out_valid", out_valid, 1);
        chk("byp_c2_out_sample", out_sample, s);
        chk("byp_c2_fir_valid", fir_valid, 0);
        step();
        chk("byp_c3_out_valid", out_valid, 0);
        chk("byp_c3_busy", busy, 0);
        prev_out = s;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fir_valid"}, fir_valid, 0);
        chk({tag, "_fir_sample"}, fir_sample, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_sample"}, out_sample, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovr"}, overrun_cnt, 0);
        chk({tag, "_to"}, timeout_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, lat, ok;
        rst_n = 1'b0; enable = 1'b1; bypass = 1'b0; shift = '0; clear_cnt = 1'b0;
        iis_valid = 1'b0; iis_sample = '0; fir_done = 1'b0; fir_y = '0;
        prev_out = '0; exp_ovr = 0; exp_to = 0;
        step(); step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_byp(16'h1234);
        run_fir(16'h0100, 64'h0000_0000_0012_3400, 8, 10, -1, 0);
        run_fir(16'h0001, 64'h0000_0001_0000_0000, 0, 3, -1, 0);
        run_fir(16'h0002, -(64'sd1 <<< 40), 0, 1, -1, 0);
        run_fir(16'h0003, -64'sd5, 0, 5, -1, 0);

        run_fir(16'h0004, 64'h0000_0000_0000_4321, 0, 6, 3, 0);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        exp_ovr = 0; exp_to = 0;
        chk_counters("clear");

        run_fir(16'h0005, 64'h7777, 0, T + 1, -1, 0);
        run_fir(16'h0006, 64'h1111, 0, T, -1, 0);
        run_fir(16'h0007, 64'h2222, 0, 0, -1, 0);
        run_fir(16'h0008, 64'h3333, 0, 4, 2, 1);

        enable    = 1'b0;
        iis_valid = 1'b1;
        step();
        iis_valid = 1'b0;
        chk("disabled_busy", busy, 0);
        chk("disabled_fir_valid", fir_valid, 0);
        chk_counters("disabled_cnt");
        enable = 1'b1;
        step();
        chk("disabled_out_valid", out_valid, 0);

        iis_valid = 1'b1; iis_sample = 16'hABCD; bypass = 1'b0;
        step();
        iis_valid = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        step();
        rst_n = 1'b1;
        prev_out = '0; exp_ovr = 0; exp_to = 0;
        step();
        chk_all_zero("after_reset");
        run_fir(16'h00AA, 64'h0000_0000_0000_0A00, 4, 7, -1, 0);

        for (int i = 0; i < 30; i++) begin
            logic [63:0] y;
            int sh, ok_k;
            if ($urandom_range(0, 4) == 0) begin
                run_byp(DS'($urandom));
            end else begin
                case ($urandom_range(0, 2))
                    0: y = {$urandom, $urandom};
                    1: y = 64'($signed(32'($urandom)) >>> $urandom_range(0, 20));
                    default: y = 64'($signed(20'($urandom)));
                endcase
                sh = $urandom_range(0, 63);
                case ($urandom_range(0, 5))
                    0: d = T + $urandom_range(1, 2);
                    1: d = T;
                    default: d = $urandom_range(1, 20);
                endcase
                lat = (d >= 1 && d <= T) ? d + 1 : T + 1;
                ok_k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lat) : -1;
                run_fir(DS'($urandom), y, sh, d, ok_k, 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_student_fir_sequencer
